// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 16-bit ALU: operand forwarding, load-use bubbles, registered EX outputs.
// Optional bubble counter output is compiled in with `define ID_EX_BUBBLE_CNT_EN.
module id_ex_operand_stage #(
   parameter int DW = 16,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [1:0]    id_aluop,
   input  logic [RW-1:0] id_rs1,
   input  logic [RW-1:0] id_rs2,
   input  logic [RW-1:0] id_rd,
   input  logic [DW-1:0] id_rd1,
   input  logic [DW-1:0] id_rd2,
   input  logic [DW-1:0] id_imm,
   input  logic          id_use_imm,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic [DW-1:0] ex_result,
   input  logic          mem_regwrite,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_result,
   output logic          load_use_stall,
`ifdef ID_EX_BUBBLE_CNT_EN
   output logic [15:0]   bubble_cnt,
`endif
   output logic          ex_valid,
   output logic [1:0]    ALUop,
   output logic [DW-1:0] srcA,
   output logic [DW-1:0] srcB,
   output logic [RW-1:0] ex_rd,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic [DW-1:0] ex_store_data
);

   localparam logic [1:0] OP_NEG = 2'b11;

   logic          ex_fwd_ok;
   logic [DW-1:0] fwd_rs1;
   logic [DW-1:0] fwd_rs2;
   logic [DW-1:0] src_b_nxt;
   logic          bubble;

   // A load in EX has no result yet, so it must never be a forwarding source.
   assign ex_fwd_ok = ex_valid & ex_regwrite & ~ex_memread;

   function automatic logic [DW-1:0] fwd(input logic [RW-1:0] rs,
                                         input logic [DW-1:0] rf_data);
      if (rs == '0)
         return '0;
      else if (ex_fwd_ok && ex_rd == rs)
         return ex_result;
      else if (mem_regwrite && mem_rd == rs)
         return mem_result;
      else
         return rf_data;
   endfunction

   // NOTE: every always_comb output gets a default on all paths, otherwise a latch is inferred.
   always_comb begin
      fwd_rs1   = fwd(id_rs1, id_rd1);
      fwd_rs2   = fwd(id_rs2, id_rd2);
      src_b_nxt = id_use_imm ? id_imm : fwd_rs2;
      if (id_aluop == OP_NEG)
         src_b_nxt = '0;
   end

   // Evaluated from the EX registers even while frozen, so a hazard survives a stall.
   assign load_use_stall = ex_valid & ex_memread & id_valid & ~flush & (ex_rd != '0) &
                           ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & ~id_use_imm));

   assign bubble = flush | load_use_stall;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ALUop         <= 2'b00;
         srcA          <= '0;
         srcB          <= '0;
         ex_rd         <= '0;
         ex_regwrite   <= 1'b0;
         ex_memread    <= 1'b0;
         ex_memwrite   <= 1'b0;
         ex_store_data <= '0;
      end else if (!stall) begin
         // Datapath always loads; a bubble is defined purely by the cleared valid/control bits.
         ALUop         <= id_aluop;
         srcA          <= fwd_rs1;
         srcB          <= src_b_nxt;
         ex_rd         <= id_rd;
         ex_store_data <= fwd_rs2;
         if (bubble) begin
            ex_valid    <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
         end else begin
            ex_valid    <= id_valid;
            ex_regwrite <= id_regwrite & id_valid;
            ex_memread  <= id_memread & id_valid;
            ex_memwrite <= id_memwrite & id_valid;
         end
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         bubble_cnt <= '0;
      else if (!stall && bubble && bubble_cnt != 16'hFFFF)
         bubble_cnt <= bubble_cnt + 16'd1;
   end
`endif

endmodule
